cpu_commit_monitor: RTL
=======================

CPU_COMMIT_MONITOR -- requirements
Module: cpu_commit_monitor

Interface
REQ-001 SHALL have parameter TRACE_DEPTH, default 8: commit trace FIFO depth; power of two, at least 2.
REQ-002 SHALL have parameter HALT_CYCLES, default 16: consecutive unchanged-PC, non-stall cycles that declare halt.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 commit_valid  input  1  CPU retired an instruction this cycle.
REQ-006 commit_rd  input  5  destination register of the retiring instruction.
REQ-007 commit_wdata  input  32  writeback value.
REQ-008 mon_forwardA / mon_forwardB  input  2 each  forwarding selects; nonzero means forwarding is active.
REQ-009 mon_stall  input  1  pipeline stall this cycle.
REQ-010 mon_branch_taken  input  1  branch taken this cycle.
REQ-011 mon_pc  input  32  current fetch PC.
REQ-012 rf_raddr  input  5  shadow register file read address.
REQ-013 rf_rdata  output  32  shadow register file data; combinational from stored state.
REQ-014 trace_valid  output  1  trace FIFO head valid.
REQ-015 trace_ready  input  1  consumer accepts the head.
REQ-016 trace_rd / trace_wdata  output  5 / 32  head entry.
REQ-017 trace_overflow  output  1  sticky flag: a commit was dropped.
REQ-018 cnt_commit, cnt_stall, cnt_branch, cnt_fwd  output  32 each  event counters.
REQ-019 halted  output  1  sticky halt-detected flag.

Function
REQ-020 Shadow RF: 32x32; on commit_valid with commit_rd!=0, entry[commit_rd] SHALL be set to commit_wdata; rf_rdata reflects the write from the next cycle (no same-cycle bypass).
REQ-021 rf_rdata SHALL be 0 for rf_raddr=0 at all times; commits to rd=0 SHALL NOT be written.
REQ-022 Trace push: commit_valid && commit_rd!=0; each entry is {commit_rd, commit_wdata}; rd=0 commits SHALL NOT be pushed.
REQ-023 Trace pop: trace_valid && trace_ready in the same cycle; FIFO SHALL be first-word-fall-through, and an entry pushed into an empty FIFO SHALL appear at the head one cycle after the push.
REQ-024 Simultaneous push and pop SHALL be legal at any occupancy, including full; occupancy is unchanged, and entry order is preserved.
REQ-025 Push while full without pop: entry SHALL be dropped, FIFO contents SHALL be unchanged, and trace_overflow SHALL be set to 1 until reset.
REQ-026 Pop while empty SHALL have no effect; trace_rd and trace_wdata are don't-care while trace_valid=0.
REQ-027 Read/write pointers SHALL wrap modulo TRACE_DEPTH; full and empty SHALL be distinguished by an occupancy count or an extra pointer bit.
REQ-028 Counter increments: cnt_commit on commit_valid (rd=0 included); cnt_stall on mon_stall; cnt_branch on mon_branch_taken; cnt_fwd on any cycle with mon_forwardA!=0 or mon_forwardB!=0. Each counter increments by at most 1 per cycle.
REQ-029 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-030 Halt detector: prev_pc register plus pc_seen flag, cleared by reset.
REQ-031 Halt counting SHALL be disabled on the first cycle after reset (pc_seen=0).
REQ-032 A qualifying cycle has pc_seen=1, mon_pc==prev_pc and mon_stall=0; each qualifying cycle increments the idle count, and any other cycle clears it to 0.
REQ-033 When the idle count reaches HALT_CYCLES, halted SHALL be set to 1 on that edge and held until reset; monitoring and counting SHALL continue after halt.

Reset
REQ-034 With rst high at a clock edge, the following SHALL be cleared: all shadow RF entries to 0, FIFO to empty (trace_valid=0), trace_overflow=0, all counters=0, halted=0, idle count=0, pc_seen=0.
REQ-035 Inputs SHALL be ignored on any cycle where rst is high; a reset asserted mid-operation discards all FIFO contents.

Verification
REQ-036 Commit rd=5, wdata=32'hDEAD_BEEF; next cycle rf_raddr=5 -> rf_rdata=32'hDEAD_BEEF, trace_valid=1, trace_rd=5, cnt_commit=1.
REQ-037 Commit rd=0, wdata=32'h1234 -> rf_rdata(0)=0, no trace entry, cnt_commit increments.
REQ-038 Hold trace_ready=0 and issue 9 commits with rd=1..9 -> 8 entries retained (rd 1..8) and trace_overflow=1; then assert trace_ready -> rd 1..8 drained in order, then trace_valid=0.
REQ-039 FIFO full, one cycle with push and pop together -> occupancy stays 8, trace_overflow stays 0, head advances by one entry.
REQ-040 mon_pc held at 32'h40 with mon_stall=0 -> halted=1 exactly 16 cycles after the first repeat. Repeat the run with mon_stall pulsed at cycle 10 -> count restarts, and halted is delayed accordingly.
REQ-041 Counters preloaded to 32'hFFFF_FFFE, two stall cycles, then reset asserted mid-stream -> cnt_stall saturates at 32'hFFFF_FFFF, then every output reads 0 after reset.

Source files
------------

// File: rtl/cpu_commit_monitor.sv
`timescale 1ns/1ps
// Commit monitor: a shadow register file, a first-word-fall-through commit trace,
// saturating event counters and a stuck-PC halt detector, all on one clock.
module cpu_commit_monitor #(
  parameter int TRACE_DEPTH = 8,
  parameter int HALT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [4:0]  commit_rd,
  input  logic [31:0] commit_wdata,
  input  logic [1:0]  mon_forwardA,
  input  logic [1:0]  mon_forwardB,
  input  logic        mon_stall,
  input  logic        mon_branch_taken,
  input  logic [31:0] mon_pc,
  input  logic [4:0]  rf_raddr,
  output logic [31:0] rf_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_wdata,
  output logic        trace_overflow,
  output logic [31:0] cnt_commit,
  output logic [31:0] cnt_stall,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_fwd,
  output logic        halted
);

  localparam int PTR_W  = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = $clog2(HALT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(TRACE_DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(HALT_CYCLES);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow register file
  // ---------------------------------------------------------------------------
  logic [31:0] rf_q [32];
  logic        push;

  assign push = commit_valid && (commit_rd != 5'd0);

  always_ff @(posedge clk) begin
    // NOTE: this array is reset entry by entry because software expects a clean
    // architectural state; that keeps it in flops. Storage that is qualified by
    // a pointer/count (the trace FIFO below) is deliberately left unreset.
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (push) begin
      rf_q[commit_rd] <= commit_wdata;
    end
  end

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf_q[rf_raddr];

  // ---------------------------------------------------------------------------
  // Commit trace FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  trace_entry_t     fifo_q [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, pop, push_ok, drop;

  assign full        = (count_q == FIFO_FULL);
  assign trace_valid = (count_q != '0);
  assign pop         = trace_valid && trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok     = push && (!full || pop);
  assign drop        = push && full && !pop;

  assign trace_rd    = fifo_q[rd_ptr_q].rd;
  assign trace_wdata = fifo_q[rd_ptr_q].wdata;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_q[wr_ptr_q] <= '{rd: commit_rd, wdata: commit_wdata};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) trace_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic [31:0] commit_nxt, stall_nxt, branch_nxt, fwd_nxt;
  logic        fwd_evt;

  assign fwd_evt    = (mon_forwardA != 2'd0) || (mon_forwardB != 2'd0);
  assign commit_nxt = sat_inc(cnt_commit, commit_valid);
  assign stall_nxt  = sat_inc(cnt_stall, mon_stall);
  assign branch_nxt = sat_inc(cnt_branch, mon_branch_taken);
  assign fwd_nxt    = sat_inc(cnt_fwd, fwd_evt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_commit <= '0;
      cnt_stall  <= '0;
      cnt_branch <= '0;
      cnt_fwd    <= '0;
    end else begin
      cnt_commit <= commit_nxt;
      cnt_stall  <= stall_nxt;
      cnt_branch <= branch_nxt;
      cnt_fwd    <= fwd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt detector: HALT_CYCLES consecutive unstalled cycles at the same PC
  // ---------------------------------------------------------------------------
  logic [31:0]       prev_pc_q;
  logic              pc_seen_q;
  logic [IDLE_W-1:0] idle_q, idle_nxt;
  logic              qualify;

  assign qualify = pc_seen_q && (mon_pc == prev_pc_q) && !mon_stall;

  always_comb begin
    // NOTE: default assigned first so no path leaves idle_nxt unassigned,
    // which would otherwise infer a latch.
    idle_nxt = '0;
    if (qualify) idle_nxt = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_q <= '0;
      pc_seen_q <= 1'b0;
      idle_q    <= '0;
      halted    <= 1'b0;
    end else begin
      prev_pc_q <= mon_pc;
      pc_seen_q <= 1'b1;
      idle_q    <= idle_nxt;
      if (qualify && (idle_nxt == IDLE_MAX)) halted <= 1'b1;
    end
  end

endmodule
